// File: rtl/seanetnackgenerator_ddr_bmpcmd_mergearbit_if.sv
// DDR bitmap command bus.
// One command beat: addr/data/len/cmd_type plus src (the source port, used only
// on the merged output side).
// Handshake: a beat moves on a rising clock edge where valid and ready are both
// high. ready may depend combinationally on valid. ready is never high for a
// port whose valid is low.
// Modports:
//   master : drives the command fields, src and valid; samples ready
//   slave  : samples the command fields and valid; drives ready
interface seanetnackgenerator_ddr_bmpcmd_mergearbit_if;
  logic [31:0]  addr;
  logic [511:0] data;
  logic [7:0]   len;
  logic [1:0]   cmd_type;
  logic         src;
  logic         valid;
  logic         ready;

  modport master (output addr, data, len, cmd_type, src, valid, input ready);
  modport slave  (input addr, data, len, cmd_type, valid, output ready);
endinterface

// File: rtl/seanetnackgenerator_ddr_bmpcmd_mergearbit.sv
// Weighted round-robin merge of the two bitmap-command streams onto the single
// DDR bitmap command interface.
//   sys_clk, sys_rst_n : clock and asynchronous active-low reset
//   p0 (slave)         : force-write-1 commands; cmd_type is expected to be 2'b11
//   p1 (slave)         : adapt-write-0/1 commands; cmd_type is expected to be 2'b00 or 2'b01
//   o  (master)        : merged command from a single registered slot; src = source port
//   dfx_sta0/1         : grant counters for port 0 and port 1 (wrap)
//   dfx_sta2           : output stall cycles (saturates)
//   dfx_sta3           : {type_err[15:0], cnt[7:0], 4'b0, cur, p0 valid, p1 valid, o valid}
// Arbiter state (cur, cnt) is exposed through dfx_sta3.
module seanetnackgenerator_ddr_bmpcmd_mergearbit #(
  parameter int unsigned P0_WEIGHT = 4,
  parameter int unsigned P1_WEIGHT = 1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  seanetnackgenerator_ddr_bmpcmd_mergearbit_if.slave  p0,
  seanetnackgenerator_ddr_bmpcmd_mergearbit_if.slave  p1,
  seanetnackgenerator_ddr_bmpcmd_mergearbit_if.master o,
  output logic [31:0] dfx_sta0,
  output logic [31:0] dfx_sta1,
  output logic [31:0] dfx_sta2,
  output logic [31:0] dfx_sta3
);
  localparam logic [7:0] W0 = 8'(P0_WEIGHT);
  localparam logic [7:0] W1 = 8'(P1_WEIGHT);

  logic         cur;
  logic [7:0]   cnt;
  logic [15:0]  type_err;
  logic         o_valid_q;
  logic [31:0]  o_addr_q;
  logic [511:0] o_data_q;
  logic [7:0]   o_len_q;
  logic [1:0]   o_type_q;
  logic         o_src_q;

  logic       any_req;
  logic       win;
  logic       load;
  logic       xfer;
  logic       bad_type;
  logic [7:0] cur_weight;

  // The winner is always a requesting port; the weight only matters while both
  // ports request, so an idle port ends the other's burst.
  always_comb begin
    any_req    = p0.valid | p1.valid;
    cur_weight = cur ? W1 : W0;
    win        = p1.valid;
    if (p0.valid && p1.valid) begin
      win = (cnt < cur_weight) ? cur : ~cur;
    end
    bad_type = win ? (p1.cmd_type == 2'b11) : (p0.cmd_type != 2'b11);
  end

  // The slot can take a new command when it is empty or being drained this cycle.
  assign load     = ~o_valid_q | o.ready;
  assign xfer     = load & any_req;
  assign p0.ready = sys_rst_n & xfer & ~win;
  assign p1.ready = sys_rst_n & xfer & win;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur       <= 1'b0;
      cnt       <= 8'd0;
      type_err  <= 16'd0;
      o_valid_q <= 1'b0;
      o_addr_q  <= '0;
      o_data_q  <= '0;
      o_len_q   <= '0;
      o_type_q  <= '0;
      o_src_q   <= 1'b0;
      dfx_sta0  <= 32'd0;
      dfx_sta1  <= 32'd0;
      dfx_sta2  <= 32'd0;
    end else begin
      if (o_valid_q && !o.ready && dfx_sta2 != 32'hFFFF_FFFF) begin
        dfx_sta2 <= dfx_sta2 + 32'd1;
      end
      if (xfer) begin
        o_valid_q <= 1'b1;
        o_src_q   <= win;
        o_addr_q  <= win ? p1.addr     : p0.addr;
        o_data_q  <= win ? p1.data     : p0.data;
        o_len_q   <= win ? p1.len      : p0.len;
        o_type_q  <= win ? p1.cmd_type : p0.cmd_type;
        if (win) dfx_sta1 <= dfx_sta1 + 32'd1;
        else     dfx_sta0 <= dfx_sta0 + 32'd1;
        if (bad_type && type_err != 16'hFFFF) begin
          type_err <= type_err + 16'd1;
        end
        if (win == cur) begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        end else begin
          cur <= win;
          cnt <= 8'd1;
        end
      end else if (load) begin
        // Nothing to load: empty the slot, keep the stale fields.
        o_valid_q <= 1'b0;
      end
    end
  end

  assign o.valid    = o_valid_q;
  assign o.addr     = o_addr_q;
  assign o.data     = o_data_q;
  assign o.len      = o_len_q;
  assign o.cmd_type = o_type_q;
  assign o.src      = o_src_q;

  assign dfx_sta3 = {type_err, cnt, 4'b0000, cur, p0.valid, p1.valid, o_valid_q};
endmodule

// File: tb/tb_seanetnackgenerator_ddr_bmpcmd_mergearbit.sv
module tb_seanetnackgenerator_ddr_bmpcmd_mergearbit;
  localparam int W = 555; // {src, type, len, addr, data}
  localparam int P0W = 4;
  localparam int P1W = 1;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  seanetnackgenerator_ddr_bmpcmd_mergearbit_if p0_bus ();
  seanetnackgenerator_ddr_bmpcmd_mergearbit_if p1_bus ();
  seanetnackgenerator_ddr_bmpcmd_mergearbit_if o_bus ();
  logic [31:0] dfx_sta0, dfx_sta1, dfx_sta2, dfx_sta3;

  seanetnackgenerator_ddr_bmpcmd_mergearbit #(.P0_WEIGHT(P0W), .P1_WEIGHT(P1W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .p0       (p0_bus),
    .p1       (p1_bus),
    .o        (o_bus),
    .dfx_sta0 (dfx_sta0),
    .dfx_sta1 (dfx_sta1),
    .dfx_sta2 (dfx_sta2),
    .dfx_sta3 (dfx_sta3)
  );

  // ---------------- scoreboard / reference model ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  // Model: who owns the current burst and how long it has run.
  int          m_owner;
  int          m_run;
  logic [31:0] m_g0, m_g1, m_stall;
  int          m_terr;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_run = 0;
    m_g0 = 0;
    m_g1 = 0;
    m_stall = 0;
    m_terr = 0;
    exp_q.delete();
  endtask

  task automatic check_dfx();
    logic [31:0] e3;
    e3 = {16'(m_terr), 8'(m_run), 4'b0000, 1'(m_owner), p0_bus.valid, p1_bus.valid,
          1'(exp_q.size() != 0)};
    check("dfx_sta0", W'(dfx_sta0), W'(m_g0));
    check("dfx_sta1", W'(dfx_sta1), W'(m_g1));
    check("dfx_sta2", W'(dfx_sta2), W'(m_stall));
    check("dfx_sta3", W'(dfx_sta3), W'(e3));
  endtask

  // ---------------- driver: one clock of stimulus + model step ----------------
  task automatic cycle(input logic v0, input logic v1, input logic rdy,
                       input logic [1:0] t0, input logic [1:0] t1);
    logic [511:0] d0, d1;
    logic         slot_full, take, pick, any;
    logic [W-1:0] word;
    @(negedge sys_clk);
    for (int i = 0; i < 16; i++) begin
      d0[i*32 +: 32] = $urandom();
      d1[i*32 +: 32] = $urandom();
    end
    p0_bus.valid = v0; p0_bus.addr = $urandom(); p0_bus.data = d0;
    p0_bus.len = 8'($urandom_range(0, 255)); p0_bus.cmd_type = t0;
    p1_bus.valid = v1; p1_bus.addr = $urandom(); p1_bus.data = d1;
    p1_bus.len = 8'($urandom_range(0, 255)); p1_bus.cmd_type = t1;
    o_bus.ready = rdy;
    #1;
    slot_full = (exp_q.size() != 0);
    take = !slot_full || rdy;
    any = v0 || v1;
    if (v0 && v1) pick = (m_run < ((m_owner == 0) ? P0W : P1W)) ? 1'(m_owner) : ~1'(m_owner);
    else          pick = v1;
    check("p0_ready", W'(p0_bus.ready), W'(take && any && !pick));
    check("p1_ready", W'(p1_bus.ready), W'(take && any && pick));
    word = pick ? {1'b1, t1, p1_bus.len, p1_bus.addr, d1} : {1'b0, t0, p0_bus.len, p0_bus.addr, d0};
    @(posedge sys_clk);
    #1;
    if (slot_full && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (slot_full && rdy) void'(exp_q.pop_front());
    if (take && any) begin
      exp_q.push_back(word);
      if (pick) m_g1++; else m_g0++;
      if (pick ? (t1 == 2'b11) : (t0 != 2'b11)) m_terr = (m_terr == 65535) ? 65535 : m_terr + 1;
      if (int'(pick) == m_owner) m_run = (m_run == 255) ? 255 : m_run + 1;
      else begin
        m_owner = int'(pick);
        m_run = 1;
      end
    end
    check("o_valid", W'(o_bus.valid), W'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("o_cmd", {o_bus.src, o_bus.cmd_type, o_bus.len, o_bus.addr, o_bus.data}, exp_q[0]);
    check_dfx();
  endtask

  task automatic do_reset();
    p0_bus.valid = 1'b0;
    p1_bus.valid = 1'b0;
    o_bus.ready = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] base2;
    logic [1:0]  rt0, rt1;
    p0_bus.addr = '0; p0_bus.data = '0; p0_bus.len = '0; p0_bus.cmd_type = '0;
    p1_bus.addr = '0; p1_bus.data = '0; p1_bus.len = '0; p1_bus.cmd_type = '0;
    do_reset();

    // Reset state.
    #1;
    check("rst_o_valid", W'(o_bus.valid), W'(0));
    check("rst_o_addr", W'(o_bus.addr), W'(0));
    check_dfx();

    // Single port-0 command, then idle.
    cycle(1, 0, 1, 2'b11, 2'b00);
    check("first_src", W'(o_bus.src), W'(0));
    cycle(0, 0, 1, 2'b11, 2'b00);
    check("first_sta0", W'(dfx_sta0), W'(1));

    // Weighted pattern: 4 x port0, 1 x port1, repeating.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 1, 2'b11, 2'b01);
      check("wrr_src", W'(o_bus.src), W'((i % 5) == 4));
    end
    check("wrr_sta0", W'(dfx_sta0), W'(16));
    check("wrr_sta1", W'(dfx_sta1), W'(4));

    // Back-pressure: 5 stall cycles, nothing granted.
    base2 = dfx_sta2;
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 2'b11, 2'b00);
    check("stall_sta2", W'(dfx_sta2 - base2), W'(5));
    check("stall_sta0", W'(dfx_sta0), W'(16));
    cycle(1, 1, 1, 2'b11, 2'b00);

    // Port-0 burst of 2, then port-1 alone takes over with cnt=1.
    do_reset();
    cycle(1, 0, 1, 2'b11, 2'b00);
    cycle(1, 0, 1, 2'b11, 2'b00);
    cycle(0, 1, 1, 2'b11, 2'b00);
    check("handover_cnt", W'(dfx_sta3[15:8]), W'(1));
    check("handover_cur", W'(dfx_sta3[3]), W'(1));

    // Port-1 command carrying the port-0 type is forwarded and counted.
    do_reset();
    cycle(0, 1, 1, 2'b11, 2'b11);
    check("terr_type", W'(o_bus.cmd_type), W'(2'b11));
    check("terr_cnt", W'(dfx_sta3[31:16]), W'(1));

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rt0 = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      rt1 = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 3) != 0), rt0, rt1);
    end

    // Asynchronous reset while the slot holds a command.
    cycle(1, 1, 0, 2'b11, 2'b00);
    cycle(1, 1, 0, 2'b11, 2'b00);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_o_valid", W'(o_bus.valid), W'(0));
    check("arst_sta0", W'(dfx_sta0), W'(0));
    check("arst_sta1", W'(dfx_sta1), W'(0));
    check("arst_sta2", W'(dfx_sta2), W'(0));
    check("arst_sta3_state", W'({dfx_sta3[31:8], dfx_sta3[3]}), W'(0));
    check("arst_p0_ready", W'(p0_bus.ready), W'(0));
    check("arst_p1_ready", W'(p1_bus.ready), W'(0));
    @(posedge sys_clk);
    #1;
    check("arst_hold_valid", W'(o_bus.valid), W'(0));
    p0_bus.valid = 1'b0;
    p1_bus.valid = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 2'b11, 2'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/seanetnackgenerator_ddr_bmpcmd_mergearbit.md
# seanetnackgenerator_ddr_bmpcmd_mergearbit

Weighted round-robin arbiter that merges the two bitmap-command streams onto the single DDR bitmap command interface. Port 0 carries force-write-1 commands and port 1 carries adapt-write-0/1 commands. It sits between the bitmap-command sub-arbiter's per-type FIFOs and the DDR bitmap write engine. It keeps one registered output slot, enforces per-port burst weights so neither stream starves, and exports DFX counters.

## Interface
- P0_WEIGHT, 4, max consecutive port-0 grants while port 1 is also requesting; legal range 1..255.
- P1_WEIGHT, 1, max consecutive port-1 grants while port 0 is also requesting; legal range 1..255.
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- p0_ddr_cmd_addr/data/len/type  in  32/512/8/2  port-0 command. Type must be 2'b11.
- p0_ddr_cmd_valid  in  1; p0_ddr_cmd_ready  out  1  port-0 handshake.
- p1_ddr_cmd_addr/data/len/type  in  32/512/8/2  port-1 command. Type must be 2'b00 or 2'b01.
- p1_ddr_cmd_valid  in  1; p1_ddr_cmd_ready  out  1  port-1 handshake.
- o_ddr_cmd_addr/data/len/type  out  32/512/8/2  merged command, registered.
- o_ddr_cmd_src  out  1  source port of the current output command.
- o_ddr_cmd_valid  out  1; o_ddr_cmd_ready  in  1  output handshake.
- dfx_sta0  out  32  port-0 grant count; wraps.
- dfx_sta1  out  32  port-1 grant count; wraps.
- dfx_sta2  out  32  output stall cycles (o_valid & ~o_ready); saturates at 0xFFFFFFFF.
- dfx_sta3  out  32  bits are:
  - [31:16] type-error count, saturating;
  - [15:8] burst count;
  - [3] current owner;
  - [2] p0_valid;
  - [1] p1_valid;
  - [0] o_ddr_cmd_valid.
  - Other bits are 0.

## Operation
- Output slot load enable: load = ~o_valid | o_ready.
- p0_ready = load & gnt0; p1_ready = load & gnt1. Ready never asserts for a port whose valid is low.
- Arbiter state:
  - cur: owner, 1 bit;
  - cnt: consecutive grants to cur, 8 bits.
- Grant decision:
  - Neither valid: no grant.
  - Exactly one port valid: grant that port.
  - Both valid: grant cur if cnt < weight(cur); otherwise grant ~cur.
- State update, only on a transfer (load & any grant):
  - Winner == cur: cnt <= cnt+1, saturating at 255.
  - Otherwise: cur <= winner, cnt <= 1.
- Slot update:
  - Transfer: load winner's fields into o_*, set o_ddr_cmd_src = winner, set o_valid = 1.
  - load with no grant: o_valid <= 0; data fields hold their last value.
- Type check on each transfer, counted in dfx_sta3[31:16]:
  - Port 0 with type != 2'b11 increments the type-error count.
  - Port 1 with type == 2'b11 increments the type-error count.
  - The command is still forwarded unchanged.
- DFX:
  - sta0 / sta1 increment on each port-0 / port-1 transfer.
  - sta2 increments each cycle with o_valid & ~o_ready.
- Reset (async assert, sync deassert by the reset tree):
  - cur=0 (port 0 owns first), cnt=0.
  - o_valid=0 and all o_* = 0.
  - p*_ready=0.
  - All dfx=0.
- Reset asserted mid-operation: the output slot and any in-flight command are discarded. Upstream FIFOs keep their contents.

## Timing
- Latency is 1 cycle from an input transfer to o_valid.
- Throughput is 1 command/cycle when o_ready is held high.
- Back-pressure:
  - o_valid & ~o_ready: both p*_ready = 0.
  - o_* stay stable until accepted.
- o_ready high with o_valid high: the next command can load in the same cycle, with no bubble.
- Weights with both ports continuously valid and o_ready=1: grants repeat P0_WEIGHT×port0 then P1_WEIGHT×port1.
- A port going idle ends its burst. The other port takes ownership on its first grant, with cnt=1.
- Arbiter state changes only on a transfer. Stall cycles do not consume weight.

## Test plan
- Reset, then p0 valid only with addr 0x100, type 11 → p0_ready=1 in that cycle. Next cycle o_valid=1, o_addr=0x100, o_src=0. Afterwards dfx_sta0=1.
- Both ports valid continuously, o_ready=1, defaults 4/1 → o_src sequence 0,0,0,0,1,0,0,0,0,1…. After 20 cycles, sta0=16 and sta1=4.
- o_ready low for 5 cycles with o_valid=1 → o_* stable, both p*_ready=0, sta2=5. No grants are counted and cnt is unchanged.
- p0 burst of 2 while p1 is idle, then p1 alone → cur switches to 1 with cnt=1. No bubble between commands.
- p1 command with type 2'b11 → forwarded with o_type=11 and o_src=1. dfx_sta3[31:16] increments to 1.
- sys_rst_n pulsed low while o_valid=1 → o_valid drops to 0 immediately (asynchronously), with cur=0, cnt=0 and all dfx=0.
